// File: rtl/tank_hit_manager.sv
// tank_hit_manager: turns bullet/tank collision levels into single hit events, tracks
// per-tank lives and the round result. Post-hit invulnerability exists only with `HIT_INVULN_EN.
module tank_hit_manager #(
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       restart,
  input  logic       bullet1tank2collision,
  input  logic       bullet2tank1collision,
  output logic [2:0] tank1_lives,
  output logic [2:0] tank2_lives,
  output logic       tank1_hit,
  output logic       tank2_hit,
  output logic       tank1_invuln,
  output logic       tank2_invuln,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam logic [2:0] LIVES_INIT = 3'(LIVES);

`ifdef HIT_INVULN_EN
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);
  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} tank_state_t;
`else
  typedef enum logic {ALIVE, DEAD} tank_state_t;
`endif

  typedef enum logic {PLAY, OVER} game_state_t;

  generate
    if (LIVES < 1 || LIVES > 7 || INVULN_FRAMES < 1 || INVULN_FRAMES > 255) begin : g_bad_param
      $error("tank_hit_manager: LIVES or INVULN_FRAMES out of range");
    end
  endgenerate

  game_state_t game_reg;
  logic [1:0]  winner_reg;
  logic [1:0]  coll;
  logic [1:0]  fatal;

  // Index 0 is tank 1 (hit by tank-2 bullets), index 1 is tank 2.
  assign coll = {bullet1tank2collision, bullet2tank1collision};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_tank
      logic        c_q;
      logic        c_q2;
      tank_state_t state_reg;
      logic [2:0]  lives_reg;
      logic        hit_reg;
      logic        hit_now;
`ifdef HIT_INVULN_EN
      logic        invuln_reg;
      logic [7:0]  cnt_reg;
`endif

      assign hit_now   = c_q && !c_q2 && (state_reg == ALIVE) && (game_reg == PLAY);
      assign fatal[gi] = hit_now && (lives_reg <= 3'd1);

      always_ff @(posedge clock) begin
        if (reset) begin
          c_q        <= 1'b0;
          c_q2       <= 1'b0;
          state_reg  <= ALIVE;
          lives_reg  <= LIVES_INIT;
          hit_reg    <= 1'b0;
`ifdef HIT_INVULN_EN
          invuln_reg <= 1'b0;
          cnt_reg    <= 8'd0;
`endif
        end else begin
          // The sampling flops keep running through restart so a held level is not an event.
          c_q  <= coll[gi];
          c_q2 <= c_q;
          if (restart) begin
            state_reg  <= ALIVE;
            lives_reg  <= LIVES_INIT;
            hit_reg    <= 1'b0;
`ifdef HIT_INVULN_EN
            invuln_reg <= 1'b0;
            cnt_reg    <= 8'd0;
`endif
          end else begin
            hit_reg <= hit_now;
            if (hit_now) begin
              if (lives_reg != 3'd0) begin
                lives_reg <= lives_reg - 3'd1;
              end
              if (fatal[gi]) begin
                state_reg <= DEAD;
              end else begin
`ifdef HIT_INVULN_EN
                state_reg  <= INVULN;
                invuln_reg <= 1'b1;
                cnt_reg    <= INVULN_LOAD;
`else
                state_reg  <= ALIVE;
`endif
              end
            end
`ifdef HIT_INVULN_EN
            else if (state_reg == INVULN && frame_tick) begin
              if (cnt_reg <= 8'd1) begin
                state_reg  <= ALIVE;
                invuln_reg <= 1'b0;
                cnt_reg    <= 8'd0;
              end else begin
                cnt_reg <= cnt_reg - 8'd1;
              end
            end
`endif
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      game_reg   <= PLAY;
      winner_reg <= 2'b00;
    end else if (game_reg == PLAY && (|fatal)) begin
      game_reg   <= OVER;
      // Bit 1 set means tank 1 died (tank 2 wins); both set is a draw.
      winner_reg <= {fatal[0], fatal[1]};
    end
  end

  assign tank1_lives = g_tank[0].lives_reg;
  assign tank2_lives = g_tank[1].lives_reg;
  assign tank1_hit   = g_tank[0].hit_reg;
  assign tank2_hit   = g_tank[1].hit_reg;
`ifdef HIT_INVULN_EN
  assign tank1_invuln = g_tank[0].invuln_reg;
  assign tank2_invuln = g_tank[1].invuln_reg;
`else
  assign tank1_invuln = 1'b0;
  assign tank2_invuln = 1'b0;
`endif
  assign game_over = (game_reg == OVER);
  assign winner    = winner_reg;

endmodule
